// File: rtl/obstacle_gen_fsm.sv
// Obstacle placer for the snake playfield. Each food pulse queues one
// placement request. A request samples a random cell, walks the snake body
// one segment per cycle looking for a collision, and then applies the head
// adjacency, spacing and density rules. An accepted cell is committed to an
// occupancy bitmap. A rejected cell is retried with fresh random coordinates.
module obstacle_gen_fsm #(
    parameter int GRID_W     = 14,
    parameter int GRID_H     = 10,
    parameter int MAX_LENGTH = 50,
    parameter int MAX_OBS    = 15,
    parameter int MAX_RETRY  = 4
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic                       obstacleFlag,
    input  logic                       s_reset,
    input  logic                       goodColl,
    input  logic [3:0]                 randX,
    input  logic [3:0]                 randY,
    input  logic [MAX_LENGTH-1:0][7:0] body,
    input  logic [7:0]                 curr_length,
    input  logic [3:0]                 x,
    input  logic [3:0]                 y,
    output logic                       obstacle,
    output logic [3:0]                 obstacleCount,
    output logic                       busy,
    output logic                       placed,
    output logic                       place_fail
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int RW    = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_SCAN   = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [NCELL-1:0]  bitmap_q,  bitmap_d;
    logic [3:0]        count_q,   count_d;
    logic [1:0]        pending_q, pending_d;
    logic [RW-1:0]     retry_q,   retry_d;
    logic [3:0]        cand_x_q,  cand_x_d;
    logic [3:0]        cand_y_q,  cand_y_d;
    logic [7:0]        len_q,     len_d;
    logic [7:0]        seg_q,     seg_d;
    logic              hit_q,     hit_d;
    logic              placed_q,  placed_d;
    logic              fail_q,    fail_d;

    logic              clear_s;
    logic              take_s;
    logic [3:0]        head_x_s;
    logic [3:0]        head_y_s;
    logic              range_bad_s;
    logic              head_adj_s;
    logic              occupied_s;
    logic              reject_s;
    logic              dense_s;
    logic [7:0]        len_clamp_s;

    // True when (xx,yy) lies on the playfield (1-based coordinates).
    function automatic logic in_grid(input int xx, input int yy);
        return (xx >= 1) && (xx <= GRID_W) && (yy >= 1) && (yy <= GRID_H);
    endfunction

    // Linear bitmap index of a cell, computed as an 8-bit unsigned value.
    function automatic logic [7:0] cell_idx(input int xx, input int yy);
        return 8'((yy - 1) * GRID_W + (xx - 1));
    endfunction

    // Bitmap bit at (xx,yy); cells off the playfield read as empty.
    function automatic logic bit_at(input logic [NCELL-1:0] bm, input int xx, input int yy);
        logic v;
        if (in_grid(xx, yy)) begin
            v = bm[cell_idx(xx, yy)];
        end else begin
            v = 1'b0;
        end
        return v;
    endfunction

    // Body segment selected by a runtime index.
    function automatic logic [7:0] seg_at(input logic [MAX_LENGTH-1:0][7:0] bus, input logic [7:0] idx);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if (idx == 8'(i)) begin
                v = bus[i];
            end else begin
                v = v;
            end
        end
        return v;
    endfunction

    assign obstacle      = bit_at(bitmap_q, int'(x), int'(y));
    assign obstacleCount = count_q;
    assign busy          = (state_q != ST_IDLE);
    assign placed        = placed_q;
    assign place_fail    = fail_q;

    // Candidate legality: range, head adjacency, spacing, density and body length clamp.
    always_comb begin
        clear_s     = (~obstacleFlag) | s_reset;
        head_x_s    = body[0][7:4];
        head_y_s    = body[0][3:0];
        range_bad_s = ~in_grid(int'(cand_x_q), int'(cand_y_q));
        head_adj_s  = ((cand_y_q == head_y_s) &&
                       (({1'b0, cand_x_q} == ({1'b0, head_x_s} + 5'd1)) ||
                        (({1'b0, cand_x_q} + 5'd1) == {1'b0, head_x_s}))) ||
                      ((cand_x_q == head_x_s) &&
                       (({1'b0, cand_y_q} == ({1'b0, head_y_s} + 5'd1)) ||
                        (({1'b0, cand_y_q} + 5'd1) == {1'b0, head_y_s})));
        occupied_s  = bit_at(bitmap_q, int'(cand_x_q),     int'(cand_y_q))     |
                      bit_at(bitmap_q, int'(cand_x_q) - 1, int'(cand_y_q) - 1) |
                      bit_at(bitmap_q, int'(cand_x_q) + 1, int'(cand_y_q) - 1) |
                      bit_at(bitmap_q, int'(cand_x_q) - 1, int'(cand_y_q) + 1) |
                      bit_at(bitmap_q, int'(cand_x_q) + 1, int'(cand_y_q) + 1);
        reject_s    = hit_q | range_bad_s | head_adj_s | occupied_s;
        dense_s     = (count_q >= 4'(MAX_OBS)) ||
                      ((curr_length >= 8'd3) &&
                       ((({6'd0, count_q} + 10'd1) << 1) >= ({2'b00, curr_length} + 10'd2)));
        if (curr_length == 8'd0) begin
            len_clamp_s = 8'd1;
        end else if (curr_length > 8'(MAX_LENGTH)) begin
            len_clamp_s = 8'(MAX_LENGTH);
        end else begin
            len_clamp_s = curr_length;
        end
    end

    // Next-state, datapath updates, request counter and synchronous clear.
    always_comb begin
        state_d   = state_q;
        bitmap_d  = bitmap_q;
        count_d   = count_q;
        pending_d = pending_q;
        retry_d   = retry_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        len_d     = len_q;
        seg_d     = seg_q;
        hit_d     = hit_q;
        placed_d  = 1'b0;
        fail_d    = 1'b0;
        take_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                retry_d = '0;
                if (goodColl || (pending_q != 2'd0)) begin
                    state_d = ST_SAMPLE;
                    take_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                cand_x_d = randX;
                cand_y_d = randY;
                len_d    = len_clamp_s;
                seg_d    = 8'd0;
                hit_d    = 1'b0;
                state_d  = ST_SCAN;
            end
            ST_SCAN: begin
                hit_d = hit_q | ({cand_x_q, cand_y_q} == seg_at(body, seg_q));
                seg_d = seg_q + 8'd1;
                if (seg_q == (len_q - 8'd1)) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_CHECK: begin
                if (reject_s) begin
                    retry_d = retry_q + RW'(1);
                    if ((int'(retry_q) + 1) < MAX_RETRY) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (dense_s) begin
                    fail_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    bitmap_d[cell_idx(int'(cand_x_q), int'(cand_y_q))] = 1'b1;
                    count_d  = count_q + 4'd1;
                    placed_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A request arriving while one is being taken leaves the queue depth unchanged.
        if (goodColl && !take_s) begin
            if (pending_q == 2'd3) begin
                pending_d = 2'd3;
            end else begin
                pending_d = pending_q + 2'd1;
            end
        end else if (!goodColl && take_s) begin
            pending_d = pending_q - 2'd1;
        end else begin
            pending_d = pending_q;
        end

        // Game reset or obstacle mode off wipes everything and aborts silently.
        if (clear_s) begin
            state_d   = ST_IDLE;
            bitmap_d  = '0;
            count_d   = 4'd0;
            pending_d = 2'd0;
            retry_d   = '0;
            cand_x_d  = 4'd0;
            cand_y_d  = 4'd0;
            len_d     = 8'd0;
            seg_d     = 8'd0;
            hit_d     = 1'b0;
            placed_d  = 1'b0;
            fail_d    = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            bitmap_q  <= '0;
            count_q   <= 4'd0;
            pending_q <= 2'd0;
            retry_q   <= '0;
            cand_x_q  <= 4'd0;
            cand_y_q  <= 4'd0;
            len_q     <= 8'd0;
            seg_q     <= 8'd0;
            hit_q     <= 1'b0;
            placed_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitmap_q  <= bitmap_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            retry_q   <= retry_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            len_q     <= len_d;
            seg_q     <= seg_d;
            hit_q     <= hit_d;
            placed_q  <= placed_d;
            fail_q    <= fail_d;
        end
    end

endmodule

// File: tb/tb_obstacle_gen_fsm.sv
// Directed bench for obstacle_gen_fsm. Every request pushes its expected
// outcome (placed or failed, resulting count and the edge of the pulse)
// onto a scoreboard queue. The pulse monitor pops the queue and compares.
module tb_obstacle_gen_fsm;

    localparam int GW = 14;
    localparam int GH = 10;
    localparam int ML = 50;

    logic                clk = 1'b0;
    logic                nRst;
    logic                obstacleFlag;
    logic                s_reset;
    logic                goodColl;
    logic [3:0]          randX;
    logic [3:0]          randY;
    logic [ML-1:0][7:0]  body;
    logic [7:0]          curr_length;
    logic [3:0]          x;
    logic [3:0]          y;
    logic                obstacle;
    logic [3:0]          obstacleCount;
    logic                busy;
    logic                placed;
    logic                place_fail;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        bit         fail;
        logic [3:0] cnt;
        int         at;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    obstacle_gen_fsm #(
        .GRID_W(GW), .GRID_H(GH), .MAX_LENGTH(ML), .MAX_OBS(15), .MAX_RETRY(4)
    ) dut (
        .clk(clk), .nRst(nRst), .obstacleFlag(obstacleFlag), .s_reset(s_reset),
        .goodColl(goodColl), .randX(randX), .randY(randY), .body(body),
        .curr_length(curr_length), .x(x), .y(y), .obstacle(obstacle),
        .obstacleCount(obstacleCount), .busy(busy), .placed(placed),
        .place_fail(place_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_pulse(input bit f, input int c, input int at);
        sb_q.push_back('{fail: f, cnt: 4'(c), at: at});
    endtask

    task automatic look(input int xx, input int yy, output logic v);
        x = 4'(xx);
        y = 4'(yy);
        #1;
        v = obstacle;
    endtask

    task automatic scan_all(output logic any);
        logic v;
        any = 1'b0;
        for (int i = 1; i <= GW; i++) begin
            for (int j = 1; j <= GH; j++) begin
                look(i, j, v);
                any = any | v;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (((busy !== 1'b0) || (sb_q.size() != 0)) && (n < budget)) begin
            tick();
            n++;
        end
        check("done_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_edge(input int target);
        while (edge_cnt < target) tick();
    endtask

    // Pulse monitor: every placed/place_fail pulse must match the queue head.
    always @(negedge clk) begin
        if ((placed === 1'b1) || (place_fail === 1'b1)) begin
            check("pulse_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("pulse_placed", 32'(placed), 32'(!mon_e.fail));
                check("pulse_fail", 32'(place_fail), 32'(mon_e.fail));
                check("pulse_count", 32'(obstacleCount), 32'(mon_e.cnt));
                check("pulse_edge", 32'(edge_cnt), 32'(mon_e.at));
            end
        end
    end

    initial begin
        int   e0;
        logic v;

        nRst = 1'b0; obstacleFlag = 1'b1; s_reset = 1'b0; goodColl = 1'b0;
        randX = 4'd0; randY = 4'd0; body = '0; curr_length = 8'd0;
        x = 4'd0; y = 4'd0;
        tick();
        tick();

        // Reset state
        check("rst_count", 32'(obstacleCount), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_placed", 32'(placed), 32'd0);
        check("rst_fail", 32'(place_fail), 32'd0);
        scan_all(v);
        check("rst_bitmap_empty", 32'(v), 32'd0);
        tick();
        nRst = 1'b1;
        tick();

        // Plain placement, L=3
        body[0] = 8'h55; body[1] = 8'h45; body[2] = 8'h35; curr_length = 8'd3;
        randX = 4'd10; randY = 4'd8;
        e0 = edge_cnt + 1;
        expect_pulse(1'b0, 1, e0 + 5);
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        check("t2_busy", 32'(busy), 32'd1);
        wait_done(40);
        check("t2_count", 32'(obstacleCount), 32'd1);
        check("t2_busy_after", 32'(busy), 32'd0);
        look(10, 8, v);  check("t2_obs_10_8", 32'(v), 32'd1);
        look(9, 8, v);   check("t2_obs_9_8", 32'(v), 32'd0);
        look(0, 8, v);   check("t2_obs_x0", 32'(v), 32'd0);
        look(15, 8, v);  check("t2_obs_x15", 32'(v), 32'd0);
        tick();

        // Body hit then retry with a clean cell
        randX = 4'd4; randY = 4'd5;
        e0 = edge_cnt + 1;
        expect_pulse(1'b0, 2, e0 + 10);
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        tick();
        randX = 4'd2; randY = 4'd2;
        wait_done(40);
        look(2, 2, v);  check("t3_obs_2_2", 32'(v), 32'd1);
        look(4, 5, v);  check("t3_obs_4_5", 32'(v), 32'd0);
        tick();

        // Spacing: place (6,6) then (7,7) is rejected on every attempt, L=2
        curr_length = 8'd2;
        randX = 4'd6; randY = 4'd6;
        e0 = edge_cnt + 1;
        expect_pulse(1'b0, 3, e0 + 4);
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        wait_done(40);
        randX = 4'd7; randY = 4'd7;
        e0 = edge_cnt + 1;
        expect_pulse(1'b1, 3, e0 + 16);
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        wait_done(60);
        check("t4_count", 32'(obstacleCount), 32'd3);
        look(7, 7, v);  check("t4_obs_7_7", 32'(v), 32'd0);
        tick();

        // Density drop: L=3, count=3 -> 2*4 >= 5, no retry
        curr_length = 8'd3;
        randX = 4'd12; randY = 4'd2;
        e0 = edge_cnt + 1;
        expect_pulse(1'b1, 3, e0 + 5);
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        wait_done(40);
        look(12, 2, v);  check("dense_obs_12_2", 32'(v), 32'd0);
        tick();

        // Head-adjacent and out-of-range candidates, L=1
        curr_length = 8'd1;
        randX = 4'd5; randY = 4'd4;
        e0 = edge_cnt + 1;
        expect_pulse(1'b1, 3, e0 + 12);
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        wait_done(40);
        randX = 4'd14; randY = 4'd11;
        e0 = edge_cnt + 1;
        expect_pulse(1'b1, 3, e0 + 12);
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        wait_done(40);
        tick();

        // Three back-to-back requests, L=2
        curr_length = 8'd2;
        randX = 4'd12; randY = 4'd2;
        e0 = edge_cnt + 1;
        expect_pulse(1'b0, 4, e0 + 4);
        expect_pulse(1'b0, 5, e0 + 9);
        expect_pulse(1'b0, 6, e0 + 14);
        goodColl = 1'b1; tick(); tick();
        randY = 4'd4; tick();
        goodColl = 1'b0;
        wait_edge(e0 + 6);
        randY = 4'd6;
        wait_done(60);
        check("t5a_count", 32'(obstacleCount), 32'd6);
        look(12, 4, v);  check("t5a_obs_12_4", 32'(v), 32'd1);
        look(12, 6, v);  check("t5a_obs_12_6", 32'(v), 32'd1);
        tick();

        // Five back-to-back requests: queue saturates, the fifth is lost
        randX = 4'd12; randY = 4'd8;
        e0 = edge_cnt + 1;
        expect_pulse(1'b0, 7, e0 + 4);
        expect_pulse(1'b0, 8, e0 + 9);
        expect_pulse(1'b0, 9, e0 + 14);
        expect_pulse(1'b0, 10, e0 + 19);
        goodColl = 1'b1; tick(); tick();
        randY = 4'd10; tick(); tick(); tick();
        goodColl = 1'b0;
        wait_edge(e0 + 6);
        randX = 4'd14; randY = 4'd2;
        wait_edge(e0 + 11);
        randY = 4'd10;
        wait_done(80);
        for (int i = 0; i < 8; i++) tick();
        check("t5b_busy_idle", 32'(busy), 32'd0);
        check("t5b_count", 32'(obstacleCount), 32'd10);
        look(14, 10, v);  check("t5b_obs_14_10", 32'(v), 32'd1);
        tick();

        // Clear by s_reset during SCAN; goodColl under clear is ignored
        randX = 4'd8; randY = 4'd2;
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        tick();
        check("t6_busy_scan", 32'(busy), 32'd1);
        s_reset = 1'b1; goodColl = 1'b1;
        tick();
        s_reset = 1'b0; goodColl = 1'b0;
        check("t6_count", 32'(obstacleCount), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        scan_all(v);
        check("t6_bitmap_empty", 32'(v), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("t6_still_idle", 32'(busy), 32'd0);

        // Clear by obstacleFlag=0 during SCAN
        e0 = edge_cnt + 1;
        expect_pulse(1'b0, 1, e0 + 4);
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        wait_done(40);
        randX = 4'd10; randY = 4'd2;
        goodColl = 1'b1; tick(); goodColl = 1'b0;
        tick();
        obstacleFlag = 1'b0;
        tick();
        obstacleFlag = 1'b1;
        check("t6f_count", 32'(obstacleCount), 32'd0);
        check("t6f_busy", 32'(busy), 32'd0);
        look(8, 2, v);  check("t6f_obs_8_2", 32'(v), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("t6f_still_idle", 32'(busy), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
